// File: rtl/conv_job_sequencer_if.sv
// Handshake bundle between the job sequencer and its neighbours:
// the descriptor queue, the fetch unit, the conv core and the writeback.
interface conv_job_sequencer_if #(
  parameter int OC2_LANES = 16,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16
);
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [CNT_W-1:0]           cfg_n_pix;
  logic [CNT_W-1:0]           cfg_n_ic;
  logic [4:0]                 cfg_act_bits;
  logic [4:0]                 cfg_wgt_bits;
  logic [4:0]                 core_act_bits;
  logic [4:0]                 core_wgt_bits;
  logic                       fetch_valid;
  logic                       fetch_ready;
  logic [CNT_W-1:0]           fetch_pix;
  logic [CNT_W-1:0]           fetch_ic;
  logic                       core_out_valid;
  logic                       core_out_ready;
  logic [OC2_LANES*ACC_W-1:0] core_partial;
  logic                       res_valid;
  logic                       res_ready;
  logic [OC2_LANES*ACC_W-1:0] res_data;
  logic [CNT_W-1:0]           res_pix;
  logic                       res_last;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  modport master (
    input  cfg_valid, cfg_n_pix, cfg_n_ic, cfg_act_bits, cfg_wgt_bits,
           fetch_ready, core_out_valid, core_partial, res_ready,
    output cfg_ready, core_act_bits, core_wgt_bits, fetch_valid, fetch_pix,
           fetch_ic, core_out_ready, res_valid, res_data, res_pix, res_last,
           busy, done, cfg_err
  );

  modport slave (
    output cfg_valid, cfg_n_pix, cfg_n_ic, cfg_act_bits, cfg_wgt_bits,
           fetch_ready, core_out_valid, core_partial, res_ready,
    input  cfg_ready, core_act_bits, core_wgt_bits, fetch_valid, fetch_pix,
           fetch_ic, core_out_ready, res_valid, res_data, res_pix, res_last,
           busy, done, cfg_err
  );
endinterface

// File: rtl/conv_job_sequencer.sv
// Job-level controller: issues pixel-major / IC-chunk-minor tile fetches and
// accumulates the core's per-chunk partials into one result vector per pixel.
module conv_job_sequencer #(
  parameter int OC2_LANES = 16,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input logic clk,
  input logic rst_n,
  conv_job_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int OW = 4;
  localparam int VW = OC2_LANES * ACC_W;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_pix_q, n_pix_d, n_ic_q, n_ic_d;
  logic [CNT_W-1:0] ip_q, ip_d, ic_q, ic_d, rp_q, rp_d, rc_q, rc_d;
  logic [CNT_W-1:0] res_pix_q, res_pix_d;
  logic [4:0]       act_bits_q, act_bits_d, wgt_bits_q, wgt_bits_d;
  logic             issue_done_q, issue_done_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic             res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic             done_q, done_d, cfg_err_q, cfg_err_d;
  logic [VW-1:0]    res_data_q, res_data_d, acc_q, acc_d, sum_vec;

  logic [CNT_W-1:0] pix_last, ic_last;
  logic             fetch_vld, core_rdy, fetch_fire, core_fire, rc_final, cfg_ok;

  function automatic logic bits_ok(input logic [4:0] b);
    return (b == 5'd2) || (b == 5'd4) || (b == 5'd8) || (b == 5'd16);
  endfunction

  function automatic logic [ACC_W-1:0] lane_add(input logic signed [ACC_W-1:0] a,
                                                input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction

  assign pix_last   = n_pix_q - CNT_W'(1);
  assign ic_last    = n_ic_q - CNT_W'(1);
  assign rc_final   = (rc_q == ic_last);
  assign fetch_vld  = (state_q == RUN) && !issue_done_q && (outst_q < OW'(MAX_OUTST));
  // A completing chunk may only land once the result slot is free or draining.
  assign core_rdy   = (outst_q != '0) && !(rc_final && res_valid_q && !bus.res_ready);
  assign fetch_fire = fetch_vld && bus.fetch_ready;
  assign core_fire  = core_rdy && bus.core_out_valid;
  assign cfg_ok     = (bus.cfg_n_pix != '0) && (bus.cfg_n_ic != '0) &&
                      bits_ok(bus.cfg_act_bits) && bits_ok(bus.cfg_wgt_bits);

  always_comb begin
    sum_vec = '0;
    for (int i = 0; i < OC2_LANES; i++) begin
      sum_vec[i*ACC_W +: ACC_W] = (rc_q == '0) ? bus.core_partial[i*ACC_W +: ACC_W]
                                 : lane_add(acc_q[i*ACC_W +: ACC_W],
                                            bus.core_partial[i*ACC_W +: ACC_W]);
    end
  end

  always_comb begin
    state_d      = state_q;
    n_pix_d      = n_pix_q;
    n_ic_d       = n_ic_q;
    ip_d         = ip_q;
    ic_d         = ic_q;
    rp_d         = rp_q;
    rc_d         = rc_q;
    act_bits_d   = act_bits_q;
    wgt_bits_d   = wgt_bits_q;
    issue_done_d = issue_done_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_pix_d    = res_pix_q;
    res_last_d   = res_last_q;
    acc_d        = acc_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    outst_d      = outst_q + OW'(fetch_fire) - OW'(core_fire);
    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (cfg_ok) begin
            n_pix_d      = bus.cfg_n_pix;
            n_ic_d       = bus.cfg_n_ic;
            act_bits_d   = bus.cfg_act_bits;
            wgt_bits_d   = bus.cfg_wgt_bits;
            ip_d         = '0;
            ic_d         = '0;
            rp_d         = '0;
            rc_d         = '0;
            issue_done_d = 1'b0;
            state_d      = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (fetch_fire) begin
          if (ic_q == ic_last) begin
            ic_d = '0;
            if (ip_q == pix_last) issue_done_d = 1'b1;
            else                  ip_d = ip_q + CNT_W'(1);
          end else begin
            ic_d = ic_q + CNT_W'(1);
          end
        end
        if (core_fire) begin
          acc_d = sum_vec;
          if (rc_final) begin
            res_data_d  = sum_vec;
            res_valid_d = 1'b1;
            res_pix_d   = rp_q;
            res_last_d  = (rp_q == pix_last);
            rc_d        = '0;
            rp_d        = rp_q + CNT_W'(1);
            if (rp_q == pix_last) state_d = DRAIN;
          end else begin
            rc_d = rc_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_pix_q      <= '0;
      n_ic_q       <= '0;
      ip_q         <= '0;
      ic_q         <= '0;
      rp_q         <= '0;
      rc_q         <= '0;
      act_bits_q   <= 5'd2;
      wgt_bits_q   <= 5'd2;
      issue_done_q <= 1'b0;
      outst_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_pix_q    <= '0;
      res_last_q   <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_pix_q      <= n_pix_d;
      n_ic_q       <= n_ic_d;
      ip_q         <= ip_d;
      ic_q         <= ic_d;
      rp_q         <= rp_d;
      rc_q         <= rc_d;
      act_bits_q   <= act_bits_d;
      wgt_bits_q   <= wgt_bits_d;
      issue_done_q <= issue_done_d;
      outst_q      <= outst_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_pix_q    <= res_pix_d;
      res_last_q   <= res_last_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Running sum is always reloaded on chunk 0, so it needs no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign bus.cfg_ready      = (state_q == IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.core_act_bits  = act_bits_q;
  assign bus.core_wgt_bits  = wgt_bits_q;
  assign bus.fetch_valid    = fetch_vld;
  assign bus.fetch_pix      = ip_q;
  assign bus.fetch_ic       = ic_q;
  assign bus.core_out_ready = core_rdy;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_pix        = res_pix_q;
  assign bus.res_last       = res_last_q;
  assign bus.done           = done_q;
  assign bus.cfg_err        = cfg_err_q;
endmodule
